// File: rtl/mux_bist_ctrl.sv
// BIST wrapper for the 4-bit 2:1 mux gate: a Galois LFSR drives the stimulus, a MISR
// compacts the responses, and a control FSM runs NUM_PAT patterns and flags pass/fail.
module mux_bist_ctrl #(
  parameter int                PAT_W      = 9,
  parameter int                RESP_W     = 4,
  parameter int                NUM_PAT    = 255,
  parameter logic [PAT_W-1:0]  LFSR_SEED  = 9'h001,
  parameter logic [PAT_W-1:0]  LFSR_MASK  = 9'h110,
  parameter logic [RESP_W-1:0] MISR_MASK  = 4'h3,
  parameter int                RESP_LAT   = 0,
  parameter logic [RESP_W-1:0] GOLDEN_SIG = 4'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [PAT_W-1:0]  pattin,
  input  logic [RESP_W-1:0] resp_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [RESP_W-1:0] signature,
  output logic [15:0]       pat_count,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_e;

  localparam logic [PAT_W-1:0] SEED = (LFSR_SEED == '0) ? PAT_W'(1) : LFSR_SEED;
  localparam logic [15:0]      LAST = 16'(NUM_PAT - 1);

  state_e              state_q, state_d;
  logic [PAT_W-1:0]    lfsr_q, lfsr_d, lfsr_step;
  logic [RESP_W-1:0]   misr_q, misr_d, misr_step;
  logic [15:0]         cnt_q, cnt_d;
  logic                pass_q, pass_d;

  assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : '0);
  assign misr_step = {misr_q[RESP_W-2:0], 1'b0} ^ (misr_q[RESP_W-1] ? MISR_MASK : '0) ^ resp_in;

  // start is a single-cycle request honoured only in IDLE/DONE; abort is honoured only
  // while busy, so when both arrive together the current state decides which one wins.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          lfsr_d  = SEED;
          misr_d  = '0;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else begin
          lfsr_d = lfsr_step;
          cnt_d  = cnt_q + 16'd1;
          // With a registered gate the first edge sees no valid response yet.
          if (RESP_LAT == 0 || cnt_q != 16'd0) misr_d = misr_step;
          if (cnt_q == LAST) begin
            if (RESP_LAT == 0) begin
              state_d = S_DONE;
              pass_d  = (misr_d == GOLDEN_SIG);
            end else begin
              state_d = S_FLUSH;
            end
          end
        end
      end
      S_FLUSH: begin
        if (abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else begin
          misr_d  = misr_step;
          state_d = S_DONE;
          pass_d  = (misr_step == GOLDEN_SIG);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      misr_q  <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  assign pattin      = (state_q == S_RUN) ? lfsr_q : '0;
  assign busy        = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign done        = (state_q == S_DONE);
  assign pass        = pass_q;
  assign signature   = misr_q;
  assign pat_count   = cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mux_bist_ctrl.sv
// Bench for mux_bist_ctrl: one instance per response latency, a behavioural gate and
// reference model, directed golden/fault/abort/reset runs followed by random-response runs.
module tb_mux_bist_ctrl;

  localparam int          NP   = 4;
  localparam logic [3:0]  GOLD = 4'hC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0]       start_s, abort_s;
  logic [1:0][8:0]  pattin_s;
  logic [1:0][3:0]  resp_s, sig_s, rnd;
  logic [1:0]       busy_s, done_s, pass_s;
  logic [1:0][15:0] cnt_s;
  logic [1:0][1:0]  dbg_s;
  logic [3:0]       resp1_q;
  int               mode;     // 0: healthy gate, 1: gate with o[3] stuck-at-0, 2: random responses
  int               checks = 0;
  int               errors = 0;

  function automatic logic [3:0] gate(input logic [8:0] p, input bit stuck);
    logic [3:0] o;
    o = p[0] ? p[8:5] : p[4:1];
    if (stuck) o[3] = 1'b0;
    return o;
  endfunction

  function automatic logic [3:0] src(input logic [8:0] p, input logic [3:0] r, input int m);
    return (m == 2) ? r : gate(p, m == 1);
  endfunction

  assign resp_s[0] = src(pattin_s[0], rnd[0], mode);
  always @(posedge clk or negedge rst_n)
    if (!rst_n) resp1_q <= 4'h0;
    else        resp1_q <= src(pattin_s[1], rnd[1], mode);
  assign resp_s[1] = resp1_q;

  mux_bist_ctrl #(.NUM_PAT(NP), .RESP_LAT(0), .GOLDEN_SIG(GOLD)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
    .pattin(pattin_s[0]), .resp_in(resp_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .pass(pass_s[0]), .signature(sig_s[0]), .pat_count(cnt_s[0]), .dbg_state_o(dbg_s[0]));

  mux_bist_ctrl #(.NUM_PAT(NP), .RESP_LAT(1), .GOLDEN_SIG(GOLD)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
    .pattin(pattin_s[1]), .resp_in(resp_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .pass(pass_s[1]), .signature(sig_s[1]), .pat_count(cnt_s[1]), .dbg_state_o(dbg_s[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Signature as polynomial division of the response stream by x^4+x+1, done on integers.
  function automatic int fold(input logic [3:0] q[$], input int n);
    int s;
    s = 0;
    for (int i = 0; i < n; i++) s = ((s * 2) % 16) ^ ((s >= 8) ? 3 : 0) ^ int'(q[i]);
    return s;
  endfunction

  task automatic chk_reset(input int d, input string tag);
    chk({tag, "_pattin"}, pattin_s[d], 0);
    chk({tag, "_busy"},   busy_s[d],   0);
    chk({tag, "_done"},   done_s[d],   0);
    chk({tag, "_pass"},   pass_s[d],   0);
    chk({tag, "_sig"},    sig_s[d],    0);
    chk({tag, "_cnt"},    cnt_s[d],    0);
  endtask

  // One run on instance d (d doubles as its response latency). abort_at / start_at / rst_at
  // name the pattern index at which that disturbance is injected (-1 = never).
  task automatic run(input int d, input int m, input int abort_at, input int start_at,
                     input int rst_at, input bit abort_with_start, output logic [3:0] fsig);
    logic [8:0] pq[$];
    logic [3:0] rq[$];
    logic [8:0] p;
    logic [3:0] r;
    int         ncap;
    int         s;
    mode = m;
    p = 9'h001;
    for (int k = 0; k < NP; k++) begin
      pq.push_back(p);
      p = (p >> 1) ^ (p[0] ? 9'h110 : 9'h000);
    end
    fsig = 4'h0;
    @(negedge clk);
    start_s[d] = 1'b1;
    abort_s[d] = abort_with_start;
    @(negedge clk);
    start_s[d] = 1'b0;
    abort_s[d] = 1'b0;
    for (int k = 0; k < NP; k++) begin
      if (k > 0) @(negedge clk);
      start_s[d] = 1'b0;
      ncap = (d == 0) ? k : ((k == 0) ? 0 : k - 1);
      s = fold(rq, ncap);
      chk("run_pattin", pattin_s[d], pq[k]);
      chk("run_busy",   busy_s[d],   1);
      chk("run_done",   done_s[d],   0);
      chk("run_cnt",    cnt_s[d],    k);
      chk("run_sig",    sig_s[d],    s);
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk_reset(d, "midrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_nodone", done_s[d], 0);
        return;
      end
      r = (m == 2) ? 4'($urandom_range(0, 15)) : gate(pq[k], m == 1);
      rnd[d] = r;
      rq.push_back(r);
      if (k == abort_at) begin
        abort_s[d] = 1'b1;
        start_s[d] = 1'b1;
        @(negedge clk);
        abort_s[d] = 1'b0;
        start_s[d] = 1'b0;
        chk("abort_busy",   busy_s[d],   0);
        chk("abort_done",   done_s[d],   0);
        chk("abort_pass",   pass_s[d],   0);
        chk("abort_pattin", pattin_s[d], 0);
        chk("abort_cnt",    cnt_s[d],    k);
        chk("abort_sig",    sig_s[d],    s);
        return;
      end
      if (k == start_at) start_s[d] = 1'b1;
    end
    @(negedge clk);
    start_s[d] = 1'b0;
    if (d == 1) begin
      chk("flush_busy",   busy_s[d],   1);
      chk("flush_done",   done_s[d],   0);
      chk("flush_pattin", pattin_s[d], 0);
      chk("flush_cnt",    cnt_s[d],    NP);
      chk("flush_sig",    sig_s[d],    fold(rq, NP - 1));
      @(negedge clk);
    end
    s = fold(rq, NP);
    chk("end_done",   done_s[d],   1);
    chk("end_busy",   busy_s[d],   0);
    chk("end_pattin", pattin_s[d], 0);
    chk("end_cnt",    cnt_s[d],    NP);
    chk("end_sig",    sig_s[d],    s);
    chk("end_pass",   pass_s[d],   (s == int'(GOLD)) ? 1 : 0);
    fsig = sig_s[d];
  endtask

  initial begin
    logic [3:0] fsig;
    rst_n   = 1'b0;
    start_s = '0;
    abort_s = '0;
    rnd     = '0;
    mode    = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset(0, "rst0");
    chk_reset(1, "rst1");
    rst_n = 1'b1;

    run(0, 0, -1, -1, -1, 1'b0, fsig);
    chk("golden_lat0_sig", fsig, 4'hC);
    run(0, 1, -1, -1, -1, 1'b0, fsig);
    chk("fault_sig", fsig, 4'hA);
    chk("fault_pass", pass_s[0], 0);
    run(1, 0, -1, -1, -1, 1'b0, fsig);
    chk("golden_lat1_sig", fsig, 4'hC);

    // abort while in DONE must leave the result untouched
    @(negedge clk);
    abort_s[1] = 1'b1;
    @(negedge clk);
    abort_s[1] = 1'b0;
    chk("done_abort_done", done_s[1], 1);
    chk("done_abort_pass", pass_s[1], 1);

    run(0, 0, 2, -1, -1, 1'b0, fsig);
    // abort while idle is a no-op
    abort_s[0] = 1'b1;
    @(negedge clk);
    abort_s[0] = 1'b0;
    chk("idle_abort_busy", busy_s[0], 0);
    chk("idle_abort_cnt",  cnt_s[0],  2);

    run(0, 0, -1, 1, -1, 1'b0, fsig);
    chk("ignored_start_sig", fsig, 4'hC);
    run(1, 0, -1, 2, -1, 1'b0, fsig);
    run(0, 0, -1, -1, 1, 1'b0, fsig);
    run(0, 0, -1, -1, -1, 1'b0, fsig);
    chk("restart_sig", fsig, 4'hC);

    repeat (24) begin
      run($urandom_range(0, 1), 2, $urandom_range(0, 9), $urandom_range(0, 6), -1,
          1'($urandom_range(0, 1)), fsig);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
